// File: rtl/mem_pkg.sv
// Shared types and helpers for banked_memory: data FSM states, wait-counter width,
// byte-lane arithmetic and the address range check used on both ports.
package mem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } data_state_t;

  localparam int BYTE_W     = 8;
  localparam int WAIT_CNT_W = 4;

  function automatic int byte_lanes(input int data_w);
    return data_w / BYTE_W;
  endfunction

  // Full-width compare so oversized addresses never alias onto low words.
  function automatic logic addr_in_range(input logic [63:0] addr, input logic [63:0] depth);
    return addr < depth;
  endfunction

endpackage

// File: rtl/mem_array.sv
// Dual-port word array: registered read port plus a read/write port with byte enables.
// 1-cycle read latency on both ports; a same-edge write to the read address is forwarded.
module mem_array
  import mem_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 8192,
  parameter int AW     = 13
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          rd_en,
  input  logic [AW-1:0]                 rd_addr,
  output logic [DATA_W-1:0]             rd_data,
  input  logic                          rw_en,
  input  logic                          rw_we,
  input  logic [byte_lanes(DATA_W)-1:0] rw_be,
  input  logic [AW-1:0]                 rw_addr,
  input  logic [DATA_W-1:0]             rw_wdata,
  output logic [DATA_W-1:0]             rw_rdata
);

  localparam int LANES = byte_lanes(DATA_W);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] merged;
  logic              wr;

  assign wr = rw_en && rw_we;

  always_comb begin
    merged = mem[rw_addr];
    for (int i = 0; i < LANES; i++) begin
      if (rw_be[i]) merged[i*BYTE_W +: BYTE_W] = rw_wdata[i*BYTE_W +: BYTE_W];
    end
  end

  always_ff @(posedge clk) begin
    if (wr) mem[rw_addr] <= merged;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data  <= '0;
      rw_rdata <= '0;
    end else begin
      if (rd_en) rd_data <= (wr && rd_addr == rw_addr) ? merged : mem[rd_addr];
      if (rw_en && !rw_we) rw_rdata <= mem[rw_addr];
    end
  end

endmodule

// File: rtl/banked_memory.sv
// Instruction/data memory: pipelined 1-cycle instruction reads; data port commits 1+DATA_WAIT
// edges after acceptance and pulses data_valid once, holding data_ready low until then.
module banked_memory
  import mem_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 32,
  parameter int DEPTH_WORDS = 8192,
  parameter int DATA_WAIT   = 0
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          inst_req,
  input  logic [ADDR_W-1:0]             inst_addr,
  output logic                          inst_valid,
  output logic [DATA_W-1:0]             inst_rdata,
  output logic                          inst_err,
  input  logic                          data_req,
  input  logic                          data_we,
  input  logic [byte_lanes(DATA_W)-1:0] data_be,
  input  logic [ADDR_W-1:0]             data_addr,
  input  logic [DATA_W-1:0]             data_wdata,
  output logic                          data_ready,
  output logic                          data_valid,
  output logic [DATA_W-1:0]             data_rdata,
  output logic                          data_err
);

  localparam int LANES = byte_lanes(DATA_W);
  localparam int AW    = $clog2(DEPTH_WORDS);

  data_state_t             state;
  logic [WAIT_CNT_W-1:0]   cnt;
  logic [ADDR_W-1:0]       lat_addr;
  logic                    lat_we;
  logic [LANES-1:0]        lat_be;
  logic [DATA_W-1:0]       lat_wdata;
  logic                    resp_we;
  logic                    resp_err;
  logic                    inst_oor;
  logic                    inst_ok;
  logic                    lat_ok;
  logic                    accept;
  logic                    commit;
  logic [DATA_W-1:0]       inst_word;
  logic [DATA_W-1:0]       data_word;

  assign inst_ok    = addr_in_range(64'(inst_addr), 64'(DEPTH_WORDS));
  assign lat_ok     = addr_in_range(64'(lat_addr), 64'(DEPTH_WORDS));
  assign data_ready = (state == ST_IDLE) && !rst;
  assign accept     = data_req && data_ready;
  // The commit is gated by rst so a reset on the commit edge drops the write.
  assign commit     = (state == ST_WAIT) && (cnt == '0) && !rst;

  mem_array #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH_WORDS),
    .AW     (AW)
  ) u_array (
    .clk      (clk),
    .rst      (rst),
    .rd_en    (inst_req && inst_ok),
    .rd_addr  (inst_addr[AW-1:0]),
    .rd_data  (inst_word),
    .rw_en    (commit && lat_ok),
    .rw_we    (lat_we),
    .rw_be    (lat_be),
    .rw_addr  (lat_addr[AW-1:0]),
    .rw_wdata (lat_wdata),
    .rw_rdata (data_word)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      resp_we    <= 1'b0;
      resp_err   <= 1'b0;
      inst_valid <= 1'b0;
      inst_oor   <= 1'b0;
    end else begin
      inst_valid <= inst_req;
      if (inst_req) inst_oor <= !inst_ok;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            cnt   <= WAIT_CNT_W'(DATA_WAIT);
            state <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (commit) begin
            resp_we  <= lat_we;
            resp_err <= !lat_ok;
            state    <= ST_RESP;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        ST_RESP: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      lat_addr  <= data_addr;
      lat_we    <= data_we;
      lat_be    <= data_be;
      lat_wdata <= data_wdata;
    end
  end

  // Error reads hold zero until the next in-range read replaces it.
  assign inst_rdata = inst_oor ? '0 : inst_word;
  assign inst_err   = inst_valid && inst_oor;
  assign data_valid = (state == ST_RESP);
  assign data_err   = data_valid && resp_err;
  assign data_rdata = (data_valid && !resp_err && !resp_we) ? data_word : '0;

endmodule

// File: tb/tb_banked_memory.sv
// Directed bench: three banked_memory instances with DATA_WAIT 0, 3 and 5 share one clock and reset.
module tb_banked_memory;

  logic        clk = 1'b0;
  logic        rst;
  logic        inst_req   [3];
  logic [31:0] inst_addr  [3];
  logic        inst_valid [3];
  logic [31:0] inst_rdata [3];
  logic        inst_err   [3];
  logic        data_req   [3];
  logic        data_we    [3];
  logic [3:0]  data_be    [3];
  logic [31:0] data_addr  [3];
  logic [31:0] data_wdata [3];
  logic        data_ready [3];
  logic        data_valid [3];
  logic [31:0] data_rdata [3];
  logic        data_err   [3];

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  banked_memory #(.DATA_W(32), .ADDR_W(32), .DEPTH_WORDS(8192), .DATA_WAIT(0)) dut0 (
    .clk(clk), .rst(rst),
    .inst_req(inst_req[0]), .inst_addr(inst_addr[0]), .inst_valid(inst_valid[0]),
    .inst_rdata(inst_rdata[0]), .inst_err(inst_err[0]),
    .data_req(data_req[0]), .data_we(data_we[0]), .data_be(data_be[0]), .data_addr(data_addr[0]),
    .data_wdata(data_wdata[0]), .data_ready(data_ready[0]), .data_valid(data_valid[0]),
    .data_rdata(data_rdata[0]), .data_err(data_err[0]));

  banked_memory #(.DATA_W(32), .ADDR_W(32), .DEPTH_WORDS(8192), .DATA_WAIT(3)) dut1 (
    .clk(clk), .rst(rst),
    .inst_req(inst_req[1]), .inst_addr(inst_addr[1]), .inst_valid(inst_valid[1]),
    .inst_rdata(inst_rdata[1]), .inst_err(inst_err[1]),
    .data_req(data_req[1]), .data_we(data_we[1]), .data_be(data_be[1]), .data_addr(data_addr[1]),
    .data_wdata(data_wdata[1]), .data_ready(data_ready[1]), .data_valid(data_valid[1]),
    .data_rdata(data_rdata[1]), .data_err(data_err[1]));

  banked_memory #(.DATA_W(32), .ADDR_W(32), .DEPTH_WORDS(8192), .DATA_WAIT(5)) dut2 (
    .clk(clk), .rst(rst),
    .inst_req(inst_req[2]), .inst_addr(inst_addr[2]), .inst_valid(inst_valid[2]),
    .inst_rdata(inst_rdata[2]), .inst_err(inst_err[2]),
    .data_req(data_req[2]), .data_we(data_we[2]), .data_be(data_be[2]), .data_addr(data_addr[2]),
    .data_wdata(data_wdata[2]), .data_ready(data_ready[2]), .data_valid(data_valid[2]),
    .data_rdata(data_rdata[2]), .data_err(data_err[2]));

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(input int d);
    int n = 0;
    while (!data_ready[d] && n < 20) begin
      step();
      n++;
    end
    if (!data_ready[d]) check_eq("ready_timeout", 32'(data_ready[d]), 32'd1);
  endtask

  // lat = edges from acceptance until data_valid is first seen; ready_low stays 1 if ready never rose.
  task automatic do_access(input int d, input logic we, input logic [31:0] addr, input logic [3:0] be,
                           input logic [31:0] wdata, output logic [31:0] rdata, output logic err,
                           output int lat, output logic ready_low);
    wait_ready(d);
    data_req[d] = 1'b1; data_we[d] = we; data_addr[d] = addr; data_be[d] = be; data_wdata[d] = wdata;
    step();
    data_req[d] = 1'b0;
    lat = 0;
    ready_low = 1'b1;
    while (!data_valid[d] && lat < 30) begin
      if (data_ready[d]) ready_low = 1'b0;
      step();
      lat++;
    end
    if (data_ready[d]) ready_low = 1'b0;
    rdata = data_rdata[d];
    err = data_err[d];
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", n_err);
    $fatal(1);
  end

  initial begin
    logic [31:0] rd;
    logic        er;
    logic        rl;
    int          lat;
    int          vcnt;

    rst = 1'b1;
    for (int d = 0; d < 3; d++) begin
      inst_req[d] = 1'b0; inst_addr[d] = '0; data_req[d] = 1'b0; data_we[d] = 1'b0;
      data_be[d] = '0; data_addr[d] = '0; data_wdata[d] = '0;
    end
    step();
    step();
    check_eq("rst_flags", {27'd0, inst_valid[0], inst_err[0], data_valid[0], data_err[0], data_ready[0]}, 32'd0);
    check_eq("rst_inst_rdata", inst_rdata[0], 32'd0);
    check_eq("rst_data_rdata", data_rdata[0], 32'd0);
    rst = 1'b0;
    step();
    check_eq("ready_after_rst", 32'(data_ready[0]), 32'd1);

    // DATA_WAIT=0 write then read
    do_access(0, 1'b1, 32'd5, 4'hF, 32'hDEADBEEF, rd, er, lat, rl);
    check_eq("w0_write_lat", 32'(lat), 32'd1);
    check_eq("w0_write_err", 32'(er), 32'd0);
    check_eq("w0_write_rdata", rd, 32'd0);
    step();
    check_eq("w0_valid_pulse", 32'(data_valid[0]), 32'd0);
    do_access(0, 1'b0, 32'd5, 4'h0, 32'd0, rd, er, lat, rl);
    check_eq("w0_read_lat", 32'(lat), 32'd1);
    check_eq("w0_read_data", rd, 32'hDEADBEEF);

    // DATA_WAIT=3 byte strobes
    do_access(1, 1'b1, 32'd5, 4'hF, 32'hDEADBEEF, rd, er, lat, rl);
    do_access(1, 1'b1, 32'd5, 4'b0101, 32'h11223344, rd, er, lat, rl);
    check_eq("w3_write_lat", 32'(lat), 32'd4);
    check_eq("w3_ready_low", 32'(rl), 32'd1);
    check_eq("w3_write_err", 32'(er), 32'd0);
    do_access(1, 1'b0, 32'd5, 4'h0, 32'd0, rd, er, lat, rl);
    check_eq("w3_be_merge", rd, 32'hDE22BE44);
    do_access(1, 1'b1, 32'd5, 4'h0, 32'hFFFFFFFF, rd, er, lat, rl);
    check_eq("w3_be0_err", 32'(er), 32'd0);
    do_access(1, 1'b0, 32'd5, 4'h0, 32'd0, rd, er, lat, rl);
    check_eq("w3_be0_unchanged", rd, 32'hDE22BE44);

    // Out of range: no aliasing onto word 0
    do_access(0, 1'b1, 32'd0, 4'hF, 32'h01020304, rd, er, lat, rl);
    do_access(0, 1'b1, 32'd8192, 4'hF, 32'hAAAAAAAA, rd, er, lat, rl);
    check_eq("oor_write_err", 32'(er), 32'd1);
    check_eq("oor_write_rdata", rd, 32'd0);
    do_access(0, 1'b0, 32'd8192, 4'h0, 32'd0, rd, er, lat, rl);
    check_eq("oor_read_err", 32'(er), 32'd1);
    check_eq("oor_read_rdata", rd, 32'd0);
    do_access(0, 1'b0, 32'd0, 4'h0, 32'd0, rd, er, lat, rl);
    check_eq("oor_no_alias", rd, 32'h01020304);
    check_eq("inrange_err", 32'(er), 32'd0);
    inst_req[0] = 1'b1; inst_addr[0] = 32'hFFFFFFFF;
    step();
    inst_req[0] = 1'b0;
    check_eq("inst_oor_flags", {30'd0, inst_valid[0], inst_err[0]}, 32'd3);
    check_eq("inst_oor_rdata", inst_rdata[0], 32'd0);

    // Write-first collision on address 9
    do_access(0, 1'b1, 32'd9, 4'hF, 32'd0, rd, er, lat, rl);
    wait_ready(0);
    data_req[0] = 1'b1; data_we[0] = 1'b1; data_addr[0] = 32'd9; data_be[0] = 4'hF; data_wdata[0] = 32'hCAFEF00D;
    step();
    data_req[0] = 1'b0;
    inst_req[0] = 1'b1; inst_addr[0] = 32'd9;
    step();
    inst_req[0] = 1'b0;
    check_eq("collide_valid", 32'(inst_valid[0]), 32'd1);
    check_eq("collide_rdata", inst_rdata[0], 32'hCAFEF00D);

    // Back-to-back instruction reads
    do_access(0, 1'b1, 32'd1, 4'hF, 32'h11111111, rd, er, lat, rl);
    do_access(0, 1'b1, 32'd2, 4'hF, 32'h22222222, rd, er, lat, rl);
    inst_req[0] = 1'b1; inst_addr[0] = 32'd0;
    step();
    check_eq("b2b_0", {31'd0, inst_valid[0]} ^ inst_rdata[0], 32'h01020305);
    inst_addr[0] = 32'd1;
    step();
    check_eq("b2b_1", {31'd0, inst_valid[0]} ^ inst_rdata[0], 32'h11111110);
    inst_addr[0] = 32'd2;
    step();
    inst_req[0] = 1'b0;
    check_eq("b2b_2", {31'd0, inst_valid[0]} ^ inst_rdata[0], 32'h22222223);
    check_eq("b2b_err", 32'(inst_err[0]), 32'd0);
    step();
    check_eq("idle_valid", 32'(inst_valid[0]), 32'd0);
    check_eq("idle_hold", inst_rdata[0], 32'h22222222);

    // Reset two cycles after acceptance with DATA_WAIT=5
    do_access(2, 1'b1, 32'd3, 4'hF, 32'h12345678, rd, er, lat, rl);
    check_eq("w5_write_lat", 32'(lat), 32'd6);
    wait_ready(2);
    data_req[2] = 1'b1; data_we[2] = 1'b1; data_addr[2] = 32'd3; data_be[2] = 4'hF; data_wdata[2] = 32'h55;
    step();
    data_req[2] = 1'b0;
    vcnt = 0;
    for (int i = 1; i <= 12; i++) begin
      step();
      if (data_valid[2]) vcnt++;
      if (i == 2) rst = 1'b1;
      if (i == 4) rst = 1'b0;
    end
    check_eq("midrst_no_valid", 32'(vcnt), 32'd0);
    check_eq("midrst_ready", 32'(data_ready[2]), 32'd1);
    do_access(2, 1'b0, 32'd3, 4'h0, 32'd0, rd, er, lat, rl);
    check_eq("midrst_preserved", rd, 32'h12345678);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
